// File: rtl/water_dispense_controller.sv
// Dispense controller: latches a requested volume, opens the valve and counts flow-meter
// pulses until it is delivered, with operator cancel and a no-flow timeout fault.
module water_dispense_controller #(
    parameter int unsigned AMOUNT_WIDTH   = 14,
    parameter int unsigned ML_PER_PULSE   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT_WIDTH  = 26
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [AMOUNT_WIDTH-1:0] requested_amount,
    input  logic                    start,
    input  logic                    cancel,
    input  logic                    flow_pulse,
    output logic                    valve_open,
    output logic                    busy,
    output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
    output logic [AMOUNT_WIDTH-1:0] remaining_amount,
    output logic                    done,
    output logic                    fault
);
    localparam int unsigned SUM_WIDTH = AMOUNT_WIDTH + 1;
    localparam logic [AMOUNT_WIDTH-1:0]  ML_STEP      = AMOUNT_WIDTH'(ML_PER_PULSE);
    localparam logic [SUM_WIDTH-1:0]     ML_STEP_WIDE = SUM_WIDTH'(ML_PER_PULSE);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                   state;
    logic                     flow_sync1;
    logic                     flow_sync2;
    logic                     flow_prev;
    logic                     flow_event_c;
    logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
    logic [SUM_WIDTH-1:0]     dispensed_sum_c;
    logic [AMOUNT_WIDTH-1:0]  dispensed_next_c;
    logic [AMOUNT_WIDTH-1:0]  remaining_next_c;
    logic                     last_pulse_c;

    // Meter pin is asynchronous: two-flop synchronizer plus one delay flop for edge detect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flow_sync1 <= 1'b0;
            flow_sync2 <= 1'b0;
            flow_prev  <= 1'b0;
        end else begin
            flow_sync1 <= flow_pulse;
            flow_sync2 <= flow_sync1;
            flow_prev  <= flow_sync2;
        end
    end

    assign flow_event_c = flow_sync2 & ~flow_prev;

    // Per-pulse volume update: dispensed saturates high, remaining floors at zero
    always_comb begin
        dispensed_sum_c  = {1'b0, dispensed_amount} + ML_STEP_WIDE;
        dispensed_next_c = dispensed_sum_c[SUM_WIDTH-1] ? '1 : dispensed_sum_c[AMOUNT_WIDTH-1:0];
        last_pulse_c     = (remaining_amount <= ML_STEP);
        remaining_next_c = last_pulse_c ? '0 : (remaining_amount - ML_STEP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            valve_open       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
            dispensed_amount <= '0;
            remaining_amount <= '0;
            timeout_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && (requested_amount != '0)) begin
                        state            <= S_OPEN;
                        valve_open       <= 1'b1;
                        busy             <= 1'b1;
                        remaining_amount <= requested_amount;
                        dispensed_amount <= '0;
                        timeout_cnt      <= '0;
                    end
                end
                S_OPEN: begin
                    if (cancel) begin
                        state            <= S_IDLE;
                        valve_open       <= 1'b0;
                        busy             <= 1'b0;
                        remaining_amount <= '0;
                    end else if (flow_event_c) begin
                        dispensed_amount <= dispensed_next_c;
                        remaining_amount <= remaining_next_c;
                        timeout_cnt      <= '0;
                        if (last_pulse_c) begin
                            state      <= S_DONE;
                            valve_open <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state      <= S_FAULT;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    if (cancel) begin
                        state            <= S_IDLE;
                        fault            <= 1'b0;
                        remaining_amount <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_dispense_controller.sv
// Bench for water_dispense_controller: two instances (1 and 4 mL per pulse) share stimulus and are
// compared against a volume-bookkeeping model of each.
module tb_water_dispense_controller;
    localparam int unsigned AW   = 14;
    localparam int unsigned TO   = 16;
    localparam int          MAXA = (1 << AW) - 1;

    int ml [2] = '{1, 4};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] requested_amount = '0;
    logic          start = 1'b0;
    logic          cancel = 1'b0;
    logic          flow_pulse = 1'b0;
    logic          valve_open [2];
    logic          busy [2];
    logic          done [2];
    logic          fault [2];
    logic [AW-1:0] dispensed_amount [2];
    logic [AW-1:0] remaining_amount [2];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: volume bookkeeping per instance
    int m_disp [2]   = '{0, 0};
    int m_rem [2]    = '{0, 0};
    int m_dones [2]  = '{0, 0};
    bit m_active [2] = '{0, 0};
    bit m_fault [2]  = '{0, 0};
    bit m_fin [2]    = '{0, 0};

    int   done_seen [2] = '{0, 0};
    int   viol [2]      = '{0, 0};
    logic done_q [2]    = '{1'b0, 1'b0};

    water_dispense_controller #(.AMOUNT_WIDTH(AW), .ML_PER_PULSE(1), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(5)) dut_ml1 (
        .clock(clock), .reset(reset), .requested_amount(requested_amount), .start(start), .cancel(cancel),
        .flow_pulse(flow_pulse), .valve_open(valve_open[0]), .busy(busy[0]), .dispensed_amount(dispensed_amount[0]),
        .remaining_amount(remaining_amount[0]), .done(done[0]), .fault(fault[0]));

    water_dispense_controller #(.AMOUNT_WIDTH(AW), .ML_PER_PULSE(4), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(5)) dut_ml4 (
        .clock(clock), .reset(reset), .requested_amount(requested_amount), .start(start), .cancel(cancel),
        .flow_pulse(flow_pulse), .valve_open(valve_open[1]), .busy(busy[1]), .dispensed_amount(dispensed_amount[1]),
        .remaining_amount(remaining_amount[1]), .done(done[1]), .fault(fault[1]));

    always #5 clock = ~clock;

    // Counts done pulses and flags done longer than one cycle or valve overlapping done/fault/!busy
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                done_seen[i]++;
                if (done_q[i] === 1'b1) viol[i]++;
            end
            if (valve_open[i] === 1'b1 && (done[i] === 1'b1 || fault[i] === 1'b1)) viol[i]++;
            if (valve_open[i] !== busy[i]) viol[i]++;
            done_q[i] = done[i];
        end
    end

    task automatic do_idle(input int n);
        m_fin = '{1'b0, 1'b0};
        repeat (n) @(negedge clock);
    endtask

    task automatic do_start(input int req);
        requested_amount = AW'(req);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        requested_amount = AW'($urandom);
        for (int i = 0; i < 2; i++)
            if (!m_active[i] && !m_fault[i] && !m_fin[i] && req != 0) begin
                m_active[i] = 1'b1;
                m_rem[i]    = req;
                m_disp[i]   = 0;
            end
        m_fin = '{1'b0, 1'b0};
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        for (int i = 0; i < 2; i++)
            if (m_active[i] || m_fault[i]) begin
                m_active[i] = 1'b0;
                m_fault[i]  = 1'b0;
                m_rem[i]    = 0;
            end
        m_fin = '{1'b0, 1'b0};
    endtask

    // One meter pulse; returns on the first sample where the resulting update is visible
    task automatic do_pulse(input int pre_gap);
        repeat (pre_gap) @(negedge clock);
        flow_pulse = 1'b1;
        repeat (2) @(negedge clock);
        flow_pulse = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            m_fin[i] = 1'b0;
            if (m_active[i]) begin
                m_disp[i] = (m_disp[i] + ml[i] > MAXA) ? MAXA : m_disp[i] + ml[i];
                if (m_rem[i] <= ml[i]) begin
                    m_rem[i]    = 0;
                    m_active[i] = 1'b0;
                    m_fin[i]    = 1'b1;
                    m_dones[i]++;
                end else begin
                    m_rem[i] = m_rem[i] - ml[i];
                end
            end
        end
    endtask

    // Pulse timed so its flow event lands on the same clock edge as a cancel
    task automatic do_collision();
        flow_pulse = 1'b1;
        repeat (2) @(negedge clock);
        flow_pulse = 1'b0;
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        for (int i = 0; i < 2; i++)
            if (m_active[i]) begin
                m_active[i] = 1'b0;
                m_rem[i]    = 0;
            end
        m_fin = '{1'b0, 1'b0};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({valve_open[i], busy[i], done[i], fault[i], dispensed_amount[i], remaining_amount[i]} !== '0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got valve=%b busy=%b done=%b fault=%b disp=%0d rem=%0d, want all 0",
                         i, valve_open[i], busy[i], done[i], fault[i], dispensed_amount[i], remaining_amount[i]);
            end
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        do_idle(2);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({valve_open[i], busy[i], done[i], fault[i], dispensed_amount[i], remaining_amount[i]} !== '0) begin
                n_bad++;
                $display("FAIL reset_release dut%0d: got valve=%b busy=%b done=%b fault=%b disp=%0d rem=%0d, want all 0",
                         i, valve_open[i], busy[i], done[i], fault[i], dispensed_amount[i], remaining_amount[i]);
            end
        end
    endtask

    task automatic test_basic();
        for (int step = 0; step < 5; step++) begin
            if (step == 0) do_start(3);
            else if (step < 4) do_pulse(step == 1 ? 0 : 7);
            else do_idle(1);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                    n_bad++;
                    $display("FAIL basic step%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b fault=%b, want disp=%0d rem=%0d valve=%b done=%b fault=%b",
                             step, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i], m_fault[i]);
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (done_seen[i] != m_dones[i] || viol[i] != 0) begin
                n_bad++;
                $display("FAIL basic_done_count dut%0d: got done=%0d violations=%0d, want done=%0d violations=0",
                         i, done_seen[i], viol[i], m_dones[i]);
            end
        end
    endtask

    task automatic test_zero_and_idle();
        for (int step = 0; step < 3; step++) begin
            if (step == 0) do_start(0);
            else if (step == 1) do_cancel();
            else do_pulse(1);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                    n_bad++;
                    $display("FAIL zero_idle step%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b fault=%b, want disp=%0d rem=%0d valve=%b done=%b fault=%b",
                             step, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i], m_fault[i]);
                end
            end
        end
    endtask

    task automatic test_cancel();
        int done_before [2];
        done_before = done_seen;
        for (int step = 0; step < 4; step++) begin
            if (step == 0) do_start(5);
            else if (step == 1) do_pulse(2);
            else if (step == 2) do_cancel();
            else do_idle(2);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                    n_bad++;
                    $display("FAIL cancel step%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b fault=%b, want disp=%0d rem=%0d valve=%b done=%b fault=%b",
                             step, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i], m_fault[i]);
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (done_seen[i] != done_before[i] || viol[i] != 0) begin
                n_bad++;
                $display("FAIL cancel_no_done dut%0d: got done=%0d violations=%0d, want done=%0d violations=0",
                         i, done_seen[i], viol[i], done_before[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int fault_at [2] = '{-1, -1};
        do_start(4);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++)
                if (fault_at[i] < 0 && fault[i] === 1'b1) fault_at[i] = n;
            if (fault_at[0] >= 0 && fault_at[1] >= 0) break;
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (fault_at[i] != int'(TO)) begin
                n_bad++;
                $display("FAIL timeout_latency dut%0d: got fault after %0d clocks (-1 = never), want %0d", i, fault_at[i], TO);
            end
            m_active[i] = 1'b0;
            m_fault[i]  = 1'b1;
        end
        for (int step = 0; step < 5; step++) begin
            if (step == 0) do_pulse(1);
            else if (step == 1) do_start(7);
            else if (step == 2) do_pulse(0);
            else if (step == 3) do_cancel();
            else do_idle(1);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                    n_bad++;
                    $display("FAIL timeout step%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b fault=%b, want disp=%0d rem=%0d valve=%b done=%b fault=%b",
                             step, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i], m_fault[i]);
                end
            end
        end
        do_start(int'($urandom_range(2, 9)));
        for (int k = 0; k < 20 && (m_active[0] || m_active[1]); k++) begin
            do_pulse(int'($urandom_range(0, 4)));
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                    n_bad++;
                    $display("FAIL timeout_recover dut%0d: got disp=%0d rem=%0d valve=%b done=%b, want disp=%0d rem=%0d valve=%b done=%b",
                             i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i]);
                end
            end
        end
        do_idle(2);
    endtask

    task automatic test_ml4_collision();
        for (int step = 0; step < 8; step++) begin
            if (step == 0) do_start(10);
            else if (step < 4) do_pulse(2);
            else if (step == 4) do_cancel();
            else if (step == 5) do_start(int'($urandom_range(30, 60)));
            else if (step == 6) do_pulse(1);
            else do_collision();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                    n_bad++;
                    $display("FAIL ml4_collision step%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b fault=%b, want disp=%0d rem=%0d valve=%b done=%b fault=%b",
                             step, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i], m_fault[i]);
                end
            end
        end
        do_idle(3);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dispensed_amount[i] !== AW'(m_disp[i]) || done_seen[i] != m_dones[i] || viol[i] != 0) begin
                n_bad++;
                $display("FAIL collision_settle dut%0d: got disp=%0d done=%0d violations=%0d, want disp=%0d done=%0d violations=0",
                         i, dispensed_amount[i], done_seen[i], viol[i], m_disp[i], m_dones[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_start(MAXA);
        for (int k = 0; k < 5000 && m_active[1]; k++) begin
            do_pulse(0);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i]} !==
                    {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i]}) begin
                    n_bad++;
                    $display("FAIL saturation pulse%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b, want disp=%0d rem=%0d valve=%b done=%b",
                             k, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i],
                             m_disp[i], m_rem[i], m_active[i], m_fin[i]);
                end
            end
        end
        do_cancel();
        do_idle(1);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dispensed_amount[i] !== AW'(m_disp[i]) || remaining_amount[i] !== '0 || done_seen[i] != m_dones[i]) begin
                n_bad++;
                $display("FAIL saturation_end dut%0d: got disp=%0d rem=%0d done=%0d, want disp=%0d rem=0 done=%0d",
                         i, dispensed_amount[i], remaining_amount[i], done_seen[i], m_disp[i], m_dones[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int trial = 0; trial < 12; trial++) begin
            do_start(int'($urandom_range(1, 25)));
            for (int k = 0; k < 30 && (m_active[0] || m_active[1]); k++) begin
                if ($urandom_range(0, 5) == 0) do_start(int'($urandom_range(0, 25)));
                else do_pulse(int'($urandom_range(0, 8)));
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if ({dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i]} !==
                        {AW'(m_disp[i]), AW'(m_rem[i]), m_active[i], m_fin[i], m_fault[i]}) begin
                        n_bad++;
                        $display("FAIL random trial%0d dut%0d: got disp=%0d rem=%0d valve=%b done=%b fault=%b, want disp=%0d rem=%0d valve=%b done=%b fault=%b",
                                 trial, i, dispensed_amount[i], remaining_amount[i], valve_open[i], done[i], fault[i],
                                 m_disp[i], m_rem[i], m_active[i], m_fin[i], m_fault[i]);
                    end
                end
                if ($urandom_range(0, 9) == 0) break;
            end
            do_cancel();
            do_idle(int'($urandom_range(1, 5)));
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (done_seen[i] != m_dones[i] || viol[i] != 0 || remaining_amount[i] !== '0) begin
                n_bad++;
                $display("FAIL random_totals dut%0d: got done=%0d violations=%0d rem=%0d, want done=%0d violations=0 rem=0",
                         i, done_seen[i], viol[i], remaining_amount[i], m_dones[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_start(50);
        do_pulse(0);
        do_pulse(1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({valve_open[i], busy[i], done[i], fault[i], dispensed_amount[i], remaining_amount[i]} !== '0) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: got valve=%b busy=%b disp=%0d rem=%0d, want all 0 before next edge",
                         i, valve_open[i], busy[i], dispensed_amount[i], remaining_amount[i]);
            end
            m_active[i] = 1'b0;
            m_fault[i]  = 1'b0;
            m_disp[i]   = 0;
            m_rem[i]    = 0;
        end
        @(negedge clock);
        reset = 1'b1;
        do_idle(1);
        do_pulse(1);
        do_idle(2);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({valve_open[i], busy[i], done[i], fault[i], dispensed_amount[i], remaining_amount[i]} !== '0) begin
                n_bad++;
                $display("FAIL idle_pulse_after_reset dut%0d: got valve=%b busy=%b disp=%0d rem=%0d, want all 0",
                         i, valve_open[i], busy[i], dispensed_amount[i], remaining_amount[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_idle();
        test_cancel();
        test_timeout();
        test_ml4_collision();
        test_random();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
